aidc_lite_ahb_sram_slave: RTL

AHB2 slave that responds to the compression engine and other bus masters. It provides a word-addressed, flop-based scratch memory for source and destination buffers. The block decodes address/data-phase pipelining, byte-lane writes and programmable wait states, and returns OKAY/ERROR responses. It sits behind the AHB2 decoder/mux, one HSEL per instance.

---
 rtl/aidc_lite_ahb_sram_slave_if.sv | 24 ++
 rtl/aidc_lite_ahb_sram_slave.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/aidc_lite_ahb_sram_slave_if.sv
// rtl/aidc_lite_ahb_sram_slave_if.sv - AHB2 slave-side bus bundle for the scratch SRAM
interface aidc_lite_ahb_sram_slave_if;
   logic        hsel_i;
   logic [31:0] haddr_i;
   logic [1:0]  htrans_i;
   logic        hwrite_i;
   logic [2:0]  hsize_i;
   logic [2:0]  hburst_i;
   logic [31:0] hwdata_i;
   logic        hready_i;
   logic [31:0] hrdata_o;
   logic        hready_o;
   logic [1:0]  hresp_o;

   modport slave (
      input  hsel_i, haddr_i, htrans_i, hwrite_i, hsize_i, hburst_i, hwdata_i, hready_i,
      output hrdata_o, hready_o, hresp_o
   );

   modport master (
      output hsel_i, haddr_i, htrans_i, hwrite_i, hsize_i, hburst_i, hwdata_i, hready_i,
      input  hrdata_o, hready_o, hresp_o
   );
endinterface

// File: rtl/aidc_lite_ahb_sram_slave.sv
// rtl/aidc_lite_ahb_sram_slave.sv - AHB2 flop-based scratch SRAM slave with wait states and ERROR response
// Optional transfer counters are enabled by AIDC_LITE_SRAM_PERF_CNT_EN.
module aidc_lite_ahb_sram_slave #(
   parameter int DEPTH_LOG2  = 8,
   parameter int WAIT_CYCLES = 0
) (
   input  logic clk,
   input  logic rst_n,
   aidc_lite_ahb_sram_slave_if.slave bus
`ifdef AIDC_LITE_SRAM_PERF_CNT_EN
   ,
   input  logic        cnt_clr_i,
   output logic [31:0] rd_cnt_o,
   output logic [31:0] wr_cnt_o,
   output logic [15:0] err_cnt_o
`endif
);
   typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_XFER, ST_ERR1, ST_ERR2} state_t;

   localparam logic [3:0] LP_WAIT_LAST = 4'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

   state_t                  r_state;
   state_t                  w_next_state;
   state_t                  w_start_state;
   logic [3:0]              r_wait_cnt;
   logic [3:0]              w_next_wait;
   logic [DEPTH_LOG2-1:0]   r_addr;
   logic [3:0]              r_be;
   logic                    r_hwrite;
   logic                    r_err;
   logic [31:0]             r_mem [2**DEPTH_LOG2];

   logic                    w_accept;
   logic                    w_err;
   logic [3:0]              w_be;
   logic                    w_load;
   logic                    w_hready;
   logic [1:0]              w_hresp;
   logic                    w_commit;

   assign w_accept = bus.hsel_i & bus.hready_i & bus.htrans_i[1];

   assign w_err = (bus.hsize_i > 3'd2)
                | ((bus.hsize_i == 3'd1) & bus.haddr_i[0])
                | ((bus.hsize_i == 3'd2) & (|bus.haddr_i[1:0]))
                | (|bus.haddr_i[31:DEPTH_LOG2+2]);

   always_comb begin
      w_be = 4'b0000;
      case (bus.hsize_i)
         3'd0:    w_be = 4'b0001 << bus.haddr_i[1:0];
         3'd1:    w_be = bus.haddr_i[1] ? 4'b1100 : 4'b0011;
         3'd2:    w_be = 4'b1111;
         default: w_be = 4'b0000;
      endcase
   end

   always_comb begin
      w_start_state = ST_IDLE;
      if (w_accept) begin
         if (w_err)                w_start_state = ST_ERR1;
         else if (WAIT_CYCLES > 0) w_start_state = ST_WAIT;
         else                      w_start_state = ST_XFER;
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_next_wait  = 4'd0;
      w_load       = 1'b0;
      w_hready     = 1'b1;
      w_hresp      = 2'd0;
      case (r_state)
         ST_WAIT: begin
            w_hready = 1'b0;
            if (r_wait_cnt == LP_WAIT_LAST) w_next_state = ST_XFER;
            else                            w_next_wait  = r_wait_cnt + 4'd1;
         end
         ST_ERR1: begin
            w_hready     = 1'b0;
            w_hresp      = 2'd1;
            w_next_state = ST_ERR2;
         end
         ST_ERR2: begin
            w_hresp      = 2'd1;
            w_next_state = w_start_state;
            w_load       = w_accept;
         end
         default: begin
            w_next_state = w_start_state;
            w_load       = w_accept;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_wait_cnt <= 4'd0;
         r_addr     <= '0;
         r_be       <= 4'd0;
         r_hwrite   <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_state    <= w_next_state;
         r_wait_cnt <= w_next_wait;
         if (w_load) begin
            r_addr   <= bus.haddr_i[DEPTH_LOG2+1:2];
            r_be     <= w_be;
            r_hwrite <= bus.hwrite_i;
            r_err    <= w_err;
         end
      end
   end

   // Gating on rst_n keeps a reset edge from committing a pending write.
   assign w_commit = rst_n && (r_state == ST_XFER) && r_hwrite && !r_err;

   always_ff @(posedge clk) begin
      if (w_commit) begin
         for (int i = 0; i < 4; i++) begin
            if (r_be[i]) r_mem[r_addr][8*i +: 8] <= bus.hwdata_i[8*i +: 8];
         end
      end
   end

   assign bus.hrdata_o = (r_state == ST_XFER) ? r_mem[r_addr] : 32'd0;
   assign bus.hready_o = w_hready;
   assign bus.hresp_o  = w_hresp;

`ifdef AIDC_LITE_SRAM_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (!rst_n || cnt_clr_i) begin
         rd_cnt_o  <= 32'd0;
         wr_cnt_o  <= 32'd0;
         err_cnt_o <= 16'd0;
      end else begin
         if (r_state == ST_XFER && !r_hwrite) rd_cnt_o  <= rd_cnt_o + 32'd1;
         if (r_state == ST_XFER && r_hwrite)  wr_cnt_o  <= wr_cnt_o + 32'd1;
         if (r_state == ST_ERR2)              err_cnt_o <= err_cnt_o + 16'd1;
      end
   end
`endif
endmodule
